// File: rtl/wb_arbiter.sv
// wb_arbiter: regfile write-back arbiter with absolute ALU priority.
// Load results wait in an in-order queue; ALU writes squash older same-index entries.
module wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int REG_W = 5,
  parameter int MEM_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alu_valid,
  input  logic [REG_W-1:0]       alu_rd,
  input  logic [MEM_W-1:0]       alu_data,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [REG_W-1:0]       ld_rd,
  input  logic [MEM_W-1:0]       ld_data,
  output logic [REG_W-1:0]       rd,
  output logic                   we,
  output logic [MEM_W-1:0]       indata,
  output logic [$clog2(DEPTH):0] q_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [REG_W-1:0] q_rd   [DEPTH];
  logic [MEM_W-1:0] q_data [DEPTH];
  logic [DEPTH-1:0] q_vld;
  logic [PW-1:0]    rptr;
  logic [PW-1:0]    wptr;

  logic             alu_w;
  logic             ld_keep;
  logic             empty;
  logic             enq;
  logic             pop;
  logic             nxt_we;
  logic [REG_W-1:0] nxt_rd;
  logic [MEM_W-1:0] nxt_data;

  assign ld_ready = (q_count < CW'(DEPTH));
  assign alu_w    = alu_valid && (alu_rd != '0);
  assign ld_keep  = ld_valid && ld_ready && (ld_rd != '0);
  assign empty    = (q_count == '0);

  always_comb begin
    enq      = 1'b0;
    pop      = 1'b0;
    nxt_we   = 1'b0;
    nxt_rd   = rd;
    nxt_data = indata;
    unique case (1'b1)
      alu_w: begin
        nxt_we   = 1'b1;
        nxt_rd   = alu_rd;
        nxt_data = alu_data;
        enq      = ld_keep;
      end
      (!alu_w && !empty): begin
        // a squashed head is retired silently
        pop    = 1'b1;
        enq    = ld_keep;
        nxt_we = q_vld[rptr];
        if (q_vld[rptr]) begin
          nxt_rd   = q_rd[rptr];
          nxt_data = q_data[rptr];
        end
      end
      (!alu_w && empty): begin
        if (ld_keep) begin
          nxt_we   = 1'b1;
          nxt_rd   = ld_rd;
          nxt_data = ld_data;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we      <= 1'b0;
      rd      <= '0;
      indata  <= '0;
      rptr    <= '0;
      wptr    <= '0;
      q_count <= '0;
      q_vld   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_rd[i]   <= '0;
        q_data[i] <= '0;
      end
    end else begin
      we      <= nxt_we;
      rd      <= nxt_rd;
      indata  <= nxt_data;
      q_count <= q_count + CW'(enq) - CW'(pop);
      for (int i = 0; i < DEPTH; i++) begin
        if (alu_w && (q_rd[i] == alu_rd)) q_vld[i] <= 1'b0;
      end
      if (pop) begin
        q_vld[rptr] <= 1'b0;
        rptr        <= rptr + PW'(1);
      end
      // the load accepted alongside the ALU write is younger: stays valid
      if (enq) begin
        q_vld[wptr]  <= 1'b1;
        q_rd[wptr]   <= ld_rd;
        q_data[wptr] <= ld_data;
        wptr         <= wptr + PW'(1);
      end
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: queue-level reference model, per-cycle compare,
// directed literal scenarios followed by phased random traffic.
module tb_wb_arbiter;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [4:0]  rd;
  logic        we;
  logic [31:0] indata;
  logic [2:0]  q_count;

  int checks = 0;
  int errors = 0;

  wb_arbiter #(.DEPTH(DEPTH), .REG_W(5), .MEM_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_rd(ld_rd), .ld_data(ld_data),
    .rd(rd), .we(we), .indata(indata), .q_count(q_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          vld;
  } ent_t;

  ent_t        mq[$];
  ent_t        e;
  bit          m_we = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_data = '0;
  bit          m_rdy;
  bit          m_alu;
  bit          m_acc;
  logic [31:0] mregs [32];
  logic [31:0] dregs [32];

  initial begin
    for (int i = 0; i < 32; i++) begin
      mregs[i] = '0;
      dregs[i] = '0;
    end
  end

  // Reference: FIFO of pending loads, ALU always wins the port
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_we   = 1'b0;
      m_rd   = '0;
      m_data = '0;
    end else begin
      m_rdy = (mq.size() < DEPTH);
      m_alu = alu_valid && (alu_rd != 0);
      m_acc = ld_valid && m_rdy && (ld_rd != 0);
      e.rd  = ld_rd;
      e.data = ld_data;
      e.vld = 1'b1;
      if (m_alu) begin
        foreach (mq[i]) if (mq[i].rd == alu_rd) mq[i].vld = 1'b0;
        m_we = 1'b1;
        m_rd = alu_rd;
        m_data = alu_data;
        if (m_acc) mq.push_back(e);
      end else if (mq.size() != 0) begin
        ent_t h;
        h = mq.pop_front();
        m_we = h.vld;
        if (h.vld) begin
          m_rd = h.rd;
          m_data = h.data;
        end
        if (m_acc) mq.push_back(e);
      end else if (m_acc) begin
        m_we = 1'b1;
        m_rd = ld_rd;
        m_data = ld_data;
      end else begin
        m_we = 1'b0;
      end
      if (m_we) mregs[m_rd] = m_data;
    end
  end

  always @(negedge clk) begin
    chk("we", we, m_we);
    if (m_we) begin
      chk("rd", rd, m_rd);
      chk("indata", indata, m_data);
    end
    chk("q_count", q_count, mq.size());
    chk("ld_ready", ld_ready, mq.size() < DEPTH);
    if (we) dregs[rd] = indata;
  end

  task automatic drive(input bit av, input logic [4:0] ar,
                       input logic [31:0] ad, input bit lv,
                       input logic [4:0] lr, input logic [31:0] ldd);
    alu_valid = av;
    alu_rd    = ar;
    alu_data  = ad;
    ld_valid  = lv;
    ld_rd     = lr;
    ld_data   = ldd;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_we", we, 0);
    chk("rst_qc", q_count, 0);
    chk("rst_rdy", ld_ready, 1);
    idle();
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_rst_we", we, 0);
    chk("post_rst_qc", q_count, 0);
  endtask

  int ap;

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (3) cyc();
    chk("reset_we", we, 0);
    chk("reset_rd", rd, 0);
    chk("reset_indata", indata, 0);
    chk("reset_qc", q_count, 0);
    chk("reset_rdy", ld_ready, 1);
    rst_n = 1'b1;
    cyc();
    chk("idle_we", we, 0);

    drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
    cyc();
    chk("alu_we", we, 1);
    chk("alu_rd", rd, 5);
    chk("alu_data", indata, 32'hDEADBEEF);
    drive(0, 0, 0, 1, 7, 32'h11);
    cyc();
    chk("byp_we", we, 1);
    chk("byp_rd", rd, 7);
    chk("byp_data", indata, 32'h11);
    chk("byp_qc", q_count, 0);

    drive(1, 3, 32'h33, 1, 4, 32'h44);
    cyc();
    chk("pair_rd0", rd, 3);
    chk("pair_qc0", q_count, 1);
    idle();
    cyc();
    chk("pair_we1", we, 1);
    chk("pair_rd1", rd, 4);
    chk("pair_d1", indata, 32'h44);
    chk("pair_qc1", q_count, 0);

    for (int i = 0; i < 4; i++) begin
      drive(1, 5'(20 + i), 32'h100 + i, 1, 5'(8 + i), 32'h80 + i);
      cyc();
    end
    chk("full_qc", q_count, 4);
    chk("full_rdy", ld_ready, 0);
    idle();
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("drain_we", we, 1);
      chk("drain_rd", rd, 8 + i);
      chk("drain_data", indata, 32'h80 + i);
      chk("drain_qc", q_count, 3 - i);
      chk("drain_rdy", ld_ready, 1);
    end

    drive(1, 1, 32'h1, 1, 9, 32'h99);
    cyc();
    chk("waw_qc0", q_count, 1);
    drive(1, 9, 32'hA, 0, 0, 0);
    cyc();
    chk("waw_rd", rd, 9);
    chk("waw_data", indata, 32'hA);
    chk("waw_qc1", q_count, 1);
    idle();
    cyc();
    chk("waw_squash_we", we, 0);
    chk("waw_qc2", q_count, 0);
    cyc();
    chk("waw_r9", dregs[9], 32'hA);

    drive(1, 0, 32'h5, 0, 0, 0);
    cyc();
    chk("z_alu_we", we, 0);
    drive(0, 0, 0, 1, 0, 32'h6);
    cyc();
    chk("z_ld_we", we, 0);
    chk("z_ld_qc", q_count, 0);

    for (int i = 0; i < 3; i++) begin
      drive(1, 2, 32'h200 + i, 1, 5'(13 + i), 32'h300 + i);
      cyc();
    end
    chk("pre_rst_qc", q_count, 3);
    pulse_reset();
    cyc();
    chk("stale_we", we, 0);

    for (int c = 0; c < 3000; c++) begin
      ap = ((c / 150) % 3 == 0) ? 20 : ((c / 150) % 3 == 1) ? 55 : 90;
      drive($urandom_range(99) < ap, 5'($urandom_range(7)), $urandom,
            $urandom_range(99) < 60, 5'($urandom_range(7)), $urandom);
      cyc();
      if (c == 1500) pulse_reset();
    end
    idle();
    repeat (8) cyc();
    for (int i = 1; i < 32; i++) chk("regfile", dregs[i], mregs[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL take parameters: DEPTH, 4, load-result queue entries (power of 2, >=2); `reg_w, 5, register index width; `mem_w, 32, data width (both from parameters.v).
REQ-002 SHALL have ports (clock and reset first):
 clk  in  1  single clock, all state on rising edge
 rst_n  in  1  asynchronous active-low reset
 alu_valid  in  1  ALU result present this cycle (no back-pressure)
 alu_rd  in  `reg_w  ALU destination index
 alu_data  in  `mem_w  ALU result
 ld_valid  in  1  load result offered
 ld_ready  out  1  load result accepted when ld_valid & ld_ready
 ld_rd  in  `reg_w  load destination index
 ld_data  in  `mem_w  load result
 rd  out  `reg_w  regfile write index
 we  out  1  regfile write enable
 indata  out  `mem_w  regfile write data
 q_count  out  $clog2(DEPTH)+1  occupied queue entries
REQ-003 SHALL be decided as: one clock; reset is asynchronous and active-low, ports named clk and rst_n.

Function
REQ-004 SHALL issue at most one regfile write per cycle; rd/we/indata registered, written value visible one cycle after input sampled.
REQ-005 SHALL give ALU absolute priority: alu_valid & alu_rd!=0 at edge N -> we=1, rd=alu_rd, indata=alu_data during cycle N+1.
REQ-006 SHALL drop any source with rd==0: accepted per handshake, never enqueued, never written.
REQ-007 SHALL drive ld_ready = (q_count < DEPTH), combinational from registered count only.
REQ-008 SHALL, with no ALU write and queue empty, write an accepted load directly (bypass) next cycle, no enqueue.
REQ-009 SHALL, with no ALU write and queue non-empty, pop head and write it; a concurrently accepted load enqueues at tail (order preserved, no bypass past older entries).
REQ-010 SHALL, when ALU writes, enqueue any accepted load; no pop that cycle.
REQ-011 SHALL keep per-entry valid bit; an ALU write to index X clears valid of every queued entry with rd==X (WAW protection), same edge.
REQ-012 SHALL NOT squash the load accepted on the same edge as an ALU write to the same index; that load is younger and enqueues valid.
REQ-013 SHALL pop an invalidated head without writing (we=0 that cycle); such pops count as queue slots freed.
REQ-014 SHALL support simultaneous enqueue and pop when full: ld_ready is 0 when full, so no enqueue; pop frees slot, ld_ready=1 next cycle.
REQ-015 SHALL use wrapping read/write pointers of $clog2(DEPTH) bits; q_count increments on enqueue, decrements on pop, unchanged on both.
REQ-016 SHALL hold we=0 in any cycle without a valid write; rd/indata then hold last value (don't-care to regfile).

Reset
REQ-017 SHALL, on rst_n low, immediately clear we, rd, indata, pointers, q_count and all valid bits to 0; ld_ready=1 after reset.
REQ-018 SHALL discard queued entries when reset asserts mid-operation; no write issued in first cycle after rst_n rises.
REQ-019 SHALL sample no inputs while rst_n is low.

Verification
REQ-020 SHALL cover: ALU-only alu_rd=5, data=0xDEADBEEF -> next cycle we=1, rd=5, indata=0xDEADBEEF; ld alone rd=7 data=0x11 -> direct write next cycle, q_count stays 0.
REQ-021 SHALL cover: ALU rd=3 and load rd=4 same edge, ALU idle after -> cycle N+1 writes r3, N+2 writes r4; q_count 1 then 0.
REQ-022 SHALL cover: 4 loads (rd=8..11) during 4 ALU cycles -> q_count=4, ld_ready=0; ALU idle -> r8..r11 written in order, ld_ready=1 after first pop.
REQ-023 SHALL cover: queued load rd=9, then ALU rd=9 data=0xA -> r9 written 0xA only; invalid entry popped with we=0; final r9=0xA.
REQ-024 SHALL cover: rd=0 from either source -> no we pulse, q_count unchanged; rst_n low with q_count=3 -> q_count=0, we=0 immediately, no stale writes after release.
